// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: LSB fetch port, ROB redirect and decoder head.
// The fetch unit sits on the master side; the surrounding pipeline sits on the slave side.
interface fetch_unit_if;
   logic        if_full;
   logic        ins_ready;
   logic [31:0] ins_value;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        issue_stall;
   logic [31:0] pc_addr;
   logic        new_ins;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        pred_taken;

   modport master (
      input  if_full, ins_ready, ins_value, redirect, redirect_pc, issue_stall,
      output pc_addr, new_ins, inst_valid, inst_out, inst_pc, pred_taken
   );

   modport slave (
      output if_full, ins_ready, ins_value, redirect, redirect_pc, issue_stall,
      input  pc_addr, new_ins, inst_valid, inst_out, inst_pc, pred_taken
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC requests to the LSB, an in-order
// instruction queue for the decoder, and ROB / static JAL redirects that
// discard responses belonging to the abandoned path.
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   localparam int             CW      = $clog2(DEPTH + 1);
   localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW:0]    LIMIT   = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0]  FULL    = CW'(DEPTH);
   localparam logic [6:0]     JAL_OP  = 7'b1101111;

   logic [31:0]   fetch_pc;
   logic          fetch_req;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] count;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   logic [31:0]   q_ins  [DEPTH];
   logic [31:0]   q_pc   [DEPTH];
   logic          q_pred [DEPTH];

   logic          resp_ok;
   logic          push;
   logic          pop;
   logic          jal_take;
   logic          issue;
   logic [CW-1:0] out_next;
   logic [CW-1:0] count_next;
   logic [31:0]   jal_pc;

   // Outstanding count after one edge; never drops below zero.
   function automatic logic [CW-1:0] out_step(input logic [CW-1:0] cur,
                                              input logic          req,
                                              input logic          rsp);
      logic [CW:0] sum;
      sum = {1'b0, cur} + {{CW{1'b0}}, req};
      if (rsp && (sum != '0)) sum = sum - (CW + 1)'(1);
      return sum[CW-1:0];
   endfunction

   // JAL target: PC plus the sign-extended J-type immediate.
   function automatic logic [31:0] jal_target(input logic [31:0] pc,
                                              input logic [31:0] ins);
      logic [31:0] imm;
      imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      return pc + imm;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + PW'(1);
   endfunction

   // Classify this cycle's response, queue movement and next-request decision.
   always_comb begin
      resp_ok    = bus.ins_ready && (outstanding != '0);
      push       = resp_ok && (discard == '0) && !bus.redirect;
      jal_take   = push && (bus.ins_value[6:0] == JAL_OP);
      jal_pc     = jal_target(resp_pc, bus.ins_value);
      pop        = (count != '0) && !bus.issue_stall;
      out_next   = out_step(outstanding, fetch_req, resp_ok);
      count_next = count;
      if (bus.redirect)       count_next = '0;
      else if (push && !pop)  count_next = count + CW'(1);
      else if (!push && pop)  count_next = count - CW'(1);
      issue = !bus.if_full && !bus.redirect && !jal_take &&
              (({1'b0, out_next} + {1'b0, count_next}) < LIMIT);
   end

   // Control state: PCs, request flag, in-flight accounting and queue pointers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         fetch_req   <= 1'b0;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
      end else begin
         outstanding <= out_next;
         fetch_req   <= issue;
         count       <= count_next;
         if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            resp_pc  <= bus.redirect_pc;
            discard  <= out_next;
            head     <= '0;
            tail     <= '0;
         end else begin
            if (jal_take) begin
               fetch_pc <= jal_pc;
               resp_pc  <= jal_pc;
               discard  <= out_next;
            end else begin
               if (fetch_req) fetch_pc <= fetch_pc + 32'd4;
               if (push) resp_pc <= resp_pc + 32'd4;
               if (resp_ok && (discard != '0)) discard <= discard - CW'(1);
            end
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
         end
      end
   end

   // Queue storage; contents only matter where count marks them live.
   always_ff @(posedge clk) begin
      if (push) begin
         q_ins[tail]  <= bus.ins_value;
         q_pc[tail]   <= resp_pc;
         q_pred[tail] <= jal_take;
      end
   end

   // The issue rule reserves room, so a push onto a full queue needs a same-edge pop.
   assert property (@(posedge clk) disable iff (!rst) !(push && !pop && (count == FULL)));

   assign bus.pc_addr    = fetch_pc;
   assign bus.new_ins    = fetch_req;
   assign bus.inst_valid = (count != '0);
   assign bus.inst_out   = (count != '0) ? q_ins[head]  : 32'h0;
   assign bus.inst_pc    = (count != '0) ? q_pc[head]   : 32'h0;
   assign bus.pred_taken = (count != '0) ? q_pred[head] : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an LSB model answering in order, a program-order
// reference of the instruction stream, and a decoupled head monitor.
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic clk = 1'b0;
   logic rst;
   fetch_unit_if bus ();

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        pred;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          tag;
      int          due;
   } req_t;

   exp_t exp_q[$];
   req_t pend[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int epoch = 0;
   int in_q  = 0;
   int lat   = 6;
   int resp_pct = 100;
   logic [31:0] req_exp;
   logic [31:0] walk_pc;

   logic        c_rst, c_stall, c_full, c_redirect, c_stray;
   logic [31:0] c_rpc;
   int          cur_tag;
   logic [31:0] cur_addr;

   logic        p_rst, p_new_ins, p_inst_valid, p_issue_stall, p_if_full;
   logic        p_redirect, p_ins_ready;
   logic [31:0] p_pc_addr, p_redirect_pc, p_addr;
   int          p_tag;

   // Program image: two JALs (forward at 0x20, backward at 0x118), else addr|0x13.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h20)  return 32'h0400006F;
      if (a == 32'h118) return 32'hFE9FF06F;
      return a | 32'h13;
   endfunction

   function automatic logic is_jal_addr(input logic [31:0] a);
      return (a == 32'h20) || (a == 32'h118);
   endfunction

   function automatic logic [31:0] jal_dest(input logic [31:0] a);
      return (a == 32'h20) ? 32'h60 : 32'h100;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic top_up();
      exp_t e;
      while (exp_q.size() < 8) begin
         e.pc   = walk_pc;
         e.ins  = mem_word(walk_pc);
         e.pred = is_jal_addr(walk_pc);
         exp_q.push_back(e);
         walk_pc = e.pred ? jal_dest(walk_pc) : walk_pc + 32'd4;
      end
   endtask

   task automatic step();
      req_t r;
      logic jal_now;
      @(posedge clk);
      #1;
      cyc++;
      jal_now = 1'b0;
      if (!p_rst) begin
         epoch++;
         pend.delete();
         exp_q.delete();
         in_q    = 0;
         walk_pc = RESET_PC;
         req_exp = RESET_PC;
         check("rst_pc_addr", bus.pc_addr, RESET_PC);
         check("rst_new_ins", bus.new_ins, 0);
         check("rst_inst_valid", bus.inst_valid, 0);
         check("rst_inst_out", bus.inst_out, 0);
         check("rst_inst_pc", bus.inst_pc, 0);
         check("rst_pred_taken", bus.pred_taken, 0);
      end else begin
         if (p_new_ins) begin
            check("req_pc", p_pc_addr, req_exp);
            pend.push_back('{p_pc_addr, epoch, cyc + lat});
            req_exp = req_exp + 32'd4;
         end
         if (p_inst_valid && !p_issue_stall) in_q--;
         if (p_redirect) begin
            epoch++;
            in_q = 0;
            exp_q.delete();
            walk_pc = p_redirect_pc;
            req_exp = p_redirect_pc;
         end else if (p_ins_ready && (p_tag == epoch)) begin
            in_q++;
            if (is_jal_addr(p_addr)) begin
               epoch++;
               req_exp = jal_dest(p_addr);
               jal_now = 1'b1;
            end
         end
         if (p_if_full || p_redirect || jal_now) check("no_issue", bus.new_ins, 0);
         check("capacity", 32'(pend.size() + in_q <= DEPTH), 1);
         check("valid_level", bus.inst_valid, 32'(in_q != 0));
      end
      top_up();
      rst             = c_rst;
      bus.issue_stall = c_stall;
      bus.if_full     = c_full;
      bus.redirect    = c_redirect;
      bus.redirect_pc = c_rpc;
      c_redirect      = 1'b0;
      bus.ins_ready   = 1'b0;
      bus.ins_value   = 32'h0;
      cur_tag         = -1;
      cur_addr        = 32'h0;
      if (c_stray) begin
         bus.ins_ready = 1'b1;
         bus.ins_value = 32'hDEAD0013;
         c_stray       = 1'b0;
      end else if (c_rst && (pend.size() != 0) && (pend[0].due <= cyc) &&
                   ($urandom_range(0, 99) < resp_pct)) begin
         r = pend.pop_front();
         bus.ins_ready = 1'b1;
         bus.ins_value = mem_word(r.addr);
         cur_tag       = r.tag;
         cur_addr      = r.addr;
      end
      p_rst         = rst;
      p_new_ins     = bus.new_ins;
      p_pc_addr     = bus.pc_addr;
      p_inst_valid  = bus.inst_valid;
      p_issue_stall = bus.issue_stall;
      p_if_full     = bus.if_full;
      p_redirect    = bus.redirect;
      p_redirect_pc = bus.redirect_pc;
      p_ins_ready   = bus.ins_ready;
      p_tag         = cur_tag;
      p_addr        = cur_addr;
   endtask

   // Head monitor: every decoder pop is compared against the program-order stream.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && bus.inst_valid && !bus.issue_stall) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL head_unexpected: got pc %0h want no entry", bus.inst_pc);
            end else begin
               e = exp_q.pop_front();
               check("head_pc", bus.inst_pc, e.pc);
               check("head_ins", bus.inst_out, e.ins);
               check("head_pred", bus.pred_taken, e.pred);
            end
         end
      end
   end

   initial begin
      bit found;
      rst = 1'b0;
      bus.if_full = 1'b0; bus.ins_ready = 1'b0; bus.ins_value = 32'h0;
      bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.issue_stall = 1'b1;
      c_rst = 1'b0; c_stall = 1'b1; c_full = 1'b0; c_redirect = 1'b0; c_stray = 1'b0;
      c_rpc = 32'h0; cur_tag = -1; cur_addr = 32'h0;
      p_rst = 1'b0; p_new_ins = 1'b0; p_pc_addr = 32'h0; p_inst_valid = 1'b0;
      p_issue_stall = 1'b1; p_if_full = 1'b0; p_redirect = 1'b0; p_redirect_pc = 32'h0;
      p_ins_ready = 1'b0; p_tag = -1; p_addr = 32'h0;
      walk_pc = RESET_PC; req_exp = RESET_PC;
      top_up();

      // Reset, release with a stray response, then fill the queue under stall.
      repeat (3) step();
      c_rst = 1'b1; c_stray = 1'b1;
      step();
      step();
      check("first_req_after_reset", bus.new_ins, 1);
      check("first_req_pc", bus.pc_addr, RESET_PC);
      repeat (30) step();
      check("stall_queue_full", bus.inst_valid, 1);
      check("stall_head_pc", bus.inst_pc, 32'h0);
      check("stall_no_pending", 32'(pend.size()), 0);
      repeat (5) begin
         step();
         check("stall_no_req", bus.new_ins, 0);
      end

      // Drain and run through the forward JAL at 0x20.
      c_stall = 1'b0;
      repeat (60) step();

      // External redirect while two requests are in flight.
      c_full = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (pend.size() == 2) found = 1'b1;
      end
      check("wait_two_outstanding", 32'(found), 1);
      c_redirect = 1'b1; c_rpc = 32'h100;
      step();
      step();
      check("redirect_flush", bus.inst_valid, 0);
      c_full = 1'b0;
      repeat (60) step();

      // if_full toggling every other cycle.
      for (int i = 0; i < 40; i++) begin
         c_full = i[0];
         step();
      end
      c_full = 1'b0;

      // Randomized traffic.
      resp_pct = 70;
      for (int i = 0; i < 1500; i++) begin
         c_full     = ($urandom_range(0, 3) == 0);
         c_stall    = ($urandom_range(0, 2) == 0);
         lat        = int'($urandom_range(1, 8));
         c_redirect = ($urandom_range(0, 49) == 0);
         c_rpc      = 32'($urandom_range(0, 127)) << 2;
         step();
      end

      // Mid-operation reset with several requests in flight.
      resp_pct = 100; lat = 6; c_full = 1'b0; c_stall = 1'b1;
      c_redirect = 1'b1; c_rpc = 32'h40;
      step();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (pend.size() >= 3) found = 1'b1;
      end
      check("wait_three_outstanding", 32'(found), 1);
      c_rst = 1'b0;
      step();
      step();
      check("midrst_pc_addr", bus.pc_addr, RESET_PC);
      check("midrst_inst_valid", bus.inst_valid, 0);
      c_rst = 1'b1; c_stray = 1'b1;
      step();
      step();
      check("req_after_midrst", bus.new_ins, 1);
      c_stall = 1'b0;
      repeat (100) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
